// File: rtl/spike_event_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : spike_event_encoder
//  Description : Detects threshold crossings of the neuron membrane potential
//                with hysteresis and a refractory window. Each detected spike
//                is timestamped and queued in a small FIFO behind a
//                valid/ready event interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_event_encoder #(
   parameter int INT_WIDTH = 3,
   parameter int FRC_WIDTH = 12,
   parameter int THRESH    = 4096,
   parameter int HYST      = 512,
   parameter int REFRAC    = 4,
   parameter int TS_WIDTH  = 16,
   parameter int DEPTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             step_valid,
   input  logic [INT_WIDTH+FRC_WIDTH:0]     v_in,
   output logic                             spike,
   output logic                             evt_valid,
   input  logic                             evt_ready,
   output logic [TS_WIDTH-1:0]              evt_ts,
   output logic [$clog2(DEPTH):0]           fifo_level,
   output logic [CNT_WIDTH-1:0]             spike_count,
   output logic [CNT_WIDTH-1:0]             drop_count,
   output logic                             overflow
);

   localparam int c_w       = 1 + INT_WIDTH + FRC_WIDTH;
   localparam int c_aw      = $clog2(DEPTH);
   localparam int c_rw      = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam int c_rearm_i = THRESH - HYST;

   // Thresholds are held one bit wider than v so THRESH-HYST cannot wrap.
   localparam logic signed [c_w:0]  c_thresh  = THRESH[c_w:0];
   localparam logic signed [c_w:0]  c_rearm   = c_rearm_i[c_w:0];
   localparam logic [c_rw-1:0]      c_refrac  = c_rw'(REFRAC);
   localparam logic [c_aw:0]        c_depth_l = (c_aw + 1)'(DEPTH);

   localparam logic [1:0] c_st_armed    = 2'd0;
   localparam logic [1:0] c_st_refrac   = 2'd1;
   localparam logic [1:0] c_st_disarmed = 2'd2;

   logic [1:0]              r_state;
   logic [1:0]              w_state_nxt;
   logic [c_rw-1:0]         r_cnt;
   logic                    w_fire;
   logic signed [c_w:0]     w_v_ext;
   logic                    w_ge_thresh;
   logic                    w_lt_rearm;
   logic [TS_WIDTH-1:0]     r_ts;
   logic                    r_spike;
   logic [CNT_WIDTH-1:0]    r_spike_count;
   logic [CNT_WIDTH-1:0]    r_drop_count;
   logic                    r_overflow;
   logic [TS_WIDTH-1:0]     r_mem [DEPTH];
   logic [c_aw-1:0]         r_wr_ptr;
   logic [c_aw-1:0]         r_rd_ptr;
   logic [c_aw:0]           r_level;
   logic                    w_full;
   logic                    w_pop;
   logic                    w_push;
   logic                    w_drop;

   assign w_v_ext     = {v_in[c_w-1], v_in};
   assign w_ge_thresh = (w_v_ext >= c_thresh);
   assign w_lt_rearm  = (w_v_ext < c_rearm);

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= c_st_armed;
      else      r_state <= w_state_nxt;
   end

   // FSM next-state logic; only step cycles move the machine
   always_comb begin
      w_state_nxt = r_state;
      if (step_valid) begin
         case (r_state)
            c_st_armed:    if (w_ge_thresh)
                              w_state_nxt = (REFRAC == 0) ? c_st_disarmed : c_st_refrac;
            c_st_refrac:   if (r_cnt == c_rw'(1)) w_state_nxt = c_st_disarmed;
            c_st_disarmed: if (w_lt_rearm) w_state_nxt = c_st_armed;
            default:       w_state_nxt = c_st_armed;
         endcase
      end
   end

   // FSM output: a spike fires only from ARMED on a step at or above threshold
   always_comb begin
      w_fire = step_valid && (r_state == c_st_armed) && w_ge_thresh;
   end

   // Refractory step counter, loaded on fire and decremented per step
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                          r_cnt <= '0;
      else if (w_fire)                                   r_cnt <= c_refrac;
      else if (step_valid && r_state == c_st_refrac)     r_cnt <= r_cnt - c_rw'(1);
   end

   // Step timestamp; an event carries the value before this step's increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            r_ts <= '0;
      else if (step_valid) r_ts <= r_ts + TS_WIDTH'(1);
   end

   // Spike pulse and saturating detection counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_spike       <= 1'b0;
         r_spike_count <= '0;
      end else begin
         r_spike <= w_fire;
         if (w_fire && r_spike_count != '1) r_spike_count <= r_spike_count + CNT_WIDTH'(1);
      end
   end

   // A pop on a full FIFO frees a slot for a same-cycle push; no empty bypass
   assign w_full = (r_level == c_depth_l);
   assign w_pop  = (r_level != '0) && evt_ready;
   assign w_push = w_fire && (!w_full || w_pop);
   assign w_drop = w_fire && w_full && !w_pop;

   // Event storage; contents are only observable while the level is nonzero
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= r_ts;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (c_aw + 1)'(1);
            2'b01:   r_level <= r_level - (c_aw + 1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Drop accounting with sticky overflow flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_drop_count <= '0;
         r_overflow   <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_count != '1) r_drop_count <= r_drop_count + CNT_WIDTH'(1);
      end
   end

   assign spike       = r_spike;
   assign evt_valid   = (r_level != '0);
   assign evt_ts      = evt_valid ? r_mem[r_rd_ptr] : '0;
   assign fifo_level  = r_level;
   assign spike_count = r_spike_count;
   assign drop_count  = r_drop_count;
   assign overflow    = r_overflow;

endmodule
`default_nettype wire
